// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load-size encodings, FP control bit indices and
// the registered MEM/WB slot layout.
package pipe_pkg;

  localparam logic [1:0] DS_WORD = 2'b00;
  localparam logic [1:0] DS_HALF = 2'b01;
  localparam logic [1:0] DS_BYTE = 2'b10;

  localparam int FP_BIT       = 0;
  localparam int DBL_BIT      = 1;
  localparam int LINK_REG_DEF = 31;

  typedef struct packed {
    logic        valid;
    logic        memtoreg;
    logic        regwr;
    logic [1:0]  dsize;
    logic        loadext;
    logic        jal;
    logic        jar;
    logic [1:0]  fpoint;
    logic [4:0]  rw;
    logic [31:0] exec;
    logic [31:0] dmem;
    logic [31:0] link;
  } mem_slot_t;

endpackage

// File: rtl/load_align.sv
// Big-endian load lane selection with sign/zero extension; flags half/word
// accesses whose address is not naturally aligned.
module load_align
  import pipe_pkg::*;
(
  input  logic [31:0] data_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  dsize_i,
  input  logic        loadext_i,
  output logic [31:0] data_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = 8'h00;
    half_sel   = 16'h0000;
    data_o     = data_i;
    misalign_o = 1'b0;
    // Lane 0 is the most significant byte.
    unique case (addr_i)
      2'd0:    byte_sel = data_i[31:24];
      2'd1:    byte_sel = data_i[23:16];
      2'd2:    byte_sel = data_i[15:8];
      default: byte_sel = data_i[7:0];
    endcase
    half_sel = addr_i[1] ? data_i[15:0] : data_i[31:16];
    case (dsize_i)
      DS_BYTE: data_o = {{24{loadext_i & byte_sel[7]}}, byte_sel};
      DS_HALF: begin
        data_o     = {{16{loadext_i & half_sel[15]}}, half_sel};
        misalign_o = addr_i[0];
      end
      default: begin
        data_o     = data_i;
        misalign_o = (addr_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// MEM/WB stage: registers MEM results, then aligns loads, picks the writeback
// source and derives integer/FP write enables purely from registered state.
module mem_wb_unit
  import pipe_pkg::*;
#(
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             mValid,
  input  logic             memtoreg_in,
  input  logic             regWr_in,
  input  logic [1:0]       dsize_in,
  input  logic             loadext_in,
  input  logic             jal_in,
  input  logic             jar_in,
  input  logic [1:0]       fPoint_in,
  input  logic [4:0]       rw_in,
  input  logic [31:0]      execResult_in,
  input  logic [31:0]      dmem_in,
  input  logic [31:0]      linkAddr_in,
  output logic [31:0]      wbData,
  output logic [4:0]       wbRw,
  output logic             wbRegWr,
  output logic             wbFpWr,
  output logic             wbDouble,
  output logic             misalign,
  output logic [CNT_W-1:0] instret
);

  localparam logic [4:0] LINK_RW = 5'(LINK_REG);

  // Valid semantics: slot_q.valid marks a real instruction in writeback; a slot
  // retires on every edge where it is valid and stall is low. There is no
  // backpressure output: upstream holds its slot while stall is high.
  mem_slot_t        slot_d, slot_q;
  logic             misalign_d, misalign_q;
  logic [CNT_W-1:0] instret_d, instret_q;

  logic [31:0] load_data;
  logic        load_mis;
  logic        is_link, fp_path, dbl_odd, mis_now, wr_ok;

  load_align u_load_align (
    .data_i     (slot_q.dmem),
    .addr_i     (slot_q.exec[1:0]),
    .dsize_i    (slot_q.dsize),
    .loadext_i  (slot_q.loadext),
    .data_o     (load_data),
    .misalign_o (load_mis)
  );

  always_comb begin
    slot_d = '{valid:    mValid,
               memtoreg: memtoreg_in,
               regwr:    regWr_in,
               dsize:    dsize_in,
               loadext:  loadext_in,
               jal:      jal_in,
               jar:      jar_in,
               fpoint:   fPoint_in,
               rw:       rw_in,
               exec:     execResult_in,
               dmem:     dmem_in,
               link:     linkAddr_in};

    is_link = slot_q.jal | slot_q.jar;
    fp_path = slot_q.fpoint[FP_BIT] & ~is_link;
    // A double FP pair must start on an even register.
    dbl_odd = slot_q.valid & slot_q.regwr & fp_path & slot_q.fpoint[DBL_BIT] & slot_q.rw[0];
    mis_now = (slot_q.valid & slot_q.memtoreg & load_mis) | dbl_odd;
    wr_ok   = slot_q.valid & slot_q.regwr & ~mis_now;

    wbData = 32'h0;
    wbRw   = 5'h0;
    if (slot_q.valid) begin
      if (is_link) begin
        wbData = slot_q.link;
        wbRw   = LINK_RW;
      end else begin
        wbData = slot_q.memtoreg ? load_data : slot_q.exec;
        wbRw   = slot_q.rw;
      end
    end
    wbFpWr   = wr_ok & fp_path;
    wbRegWr  = wr_ok & ~fp_path & (wbRw != 5'h0);
    wbDouble = wbFpWr & slot_q.fpoint[DBL_BIT];

    misalign_d = misalign_q | (~stall & mis_now);
    instret_d  = (~stall & slot_q.valid) ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= '0;
      misalign_q <= 1'b0;
      instret_q  <= '0;
    end else begin
      if (flush)       slot_q.valid <= 1'b0;
      else if (!stall) slot_q       <= slot_d;
      misalign_q <= misalign_d;
      instret_q  <= instret_d;
    end
  end

  assign misalign = misalign_q;
  assign instret  = instret_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Directed scoreboard bench for mem_wb_unit: the driver queues hand-computed
// expectations tagged with the edge they apply to; a monitor checks them.
module tb_mem_wb_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush, mValid, memtoreg_in, regWr_in, loadext_in;
  logic        jal_in, jar_in;
  logic [1:0]  dsize_in, fPoint_in;
  logic [4:0]  rw_in;
  logic [31:0] execResult_in, dmem_in, linkAddr_in;
  logic [31:0] wbData;
  logic [4:0]  wbRw;
  logic        wbRegWr, wbFpWr, wbDouble, misalign;
  logic [31:0] instret;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] data;
    logic [4:0]  rw;
    logic        regwr, fpwr, dbl, mis;
    logic [31:0] cnt;
    bit          chk_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_pass  = 0;

  mem_wb_unit #(.LINK_REG(31), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .mValid(mValid),
    .memtoreg_in(memtoreg_in), .regWr_in(regWr_in), .dsize_in(dsize_in),
    .loadext_in(loadext_in), .jal_in(jal_in), .jar_in(jar_in),
    .fPoint_in(fPoint_in), .rw_in(rw_in), .execResult_in(execResult_in),
    .dmem_in(dmem_in), .linkAddr_in(linkAddr_in), .wbData(wbData), .wbRw(wbRw),
    .wbRegWr(wbRegWr), .wbFpWr(wbFpWr), .wbDouble(wbDouble),
    .misalign(misalign), .instret(instret)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Driver tasks
  task automatic set_in(input logic mv, input logic m2r, input logic rwr,
                        input logic [1:0] ds, input logic le, input logic jl,
                        input logic jr, input logic [1:0] fp, input logic [4:0] rd,
                        input logic [31:0] ex, input logic [31:0] dm,
                        input logic [31:0] lk);
    mValid = mv; memtoreg_in = m2r; regWr_in = rwr; dsize_in = ds;
    loadext_in = le; jal_in = jl; jar_in = jr; fPoint_in = fp; rw_in = rd;
    execResult_in = ex; dmem_in = dm; linkAddr_in = lk;
  endtask

  task automatic ctl(input logic r, input logic s, input logic f);
    reset = r; stall = s; flush = f;
  endtask

  task automatic expect_next(input string name, input logic [31:0] data,
                             input logic [4:0] rw, input logic regwr,
                             input logic fpwr, input logic dbl, input logic mis,
                             input logic [31:0] cnt, input bit chk_cnt);
    exp_t e;
    e.cyc = cyc_cnt + 1; e.name = name; e.data = data; e.rw = rw;
    e.regwr = regwr; e.fpwr = fpwr; e.dbl = dbl; e.mis = mis;
    e.cnt = cnt; e.chk_cnt = chk_cnt;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard / monitor
  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp(e.name, "wbData",   wbData,           e.data);
      cmp(e.name, "wbRw",     32'(wbRw),        32'(e.rw));
      cmp(e.name, "wbRegWr",  32'(wbRegWr),     32'(e.regwr));
      cmp(e.name, "wbFpWr",   32'(wbFpWr),      32'(e.fpwr));
      cmp(e.name, "wbDouble", 32'(wbDouble),    32'(e.dbl));
      cmp(e.name, "misalign", 32'(misalign),    32'(e.mis));
      if (e.chk_cnt) cmp(e.name, "instret", instret, e.cnt);
    end
  end

  // Stimulus
  initial begin
    ctl(1, 0, 0);
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    expect_next("reset", 32'h0, 5'd0, 0, 0, 0, 0, 32'd0, 1);
    tick();
    ctl(0, 0, 0);
    expect_next("idle", 32'h0, 5'd0, 0, 0, 0, 0, 32'd0, 1);
    tick();

    // ALU op; it retires (instret counts) on the following edge
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd5, 32'h1234, 32'h0, 32'h0);
    expect_next("alu_r5", 32'h1234, 5'd5, 1, 0, 0, 0, 32'd0, 0);
    tick();

    // Byte loads across all lanes
    set_in(1, 1, 1, 2'b10, 1, 0, 0, 2'b00, 5'd8, 32'h100, 32'h80FF7F01, 32'h0);
    expect_next("lb_a0", 32'hFFFFFF80, 5'd8, 1, 0, 0, 0, 32'd1, 1);
    tick();
    set_in(1, 1, 1, 2'b10, 1, 0, 0, 2'b00, 5'd8, 32'h101, 32'h80FF7F01, 32'h0);
    expect_next("lb_a1", 32'hFFFFFFFF, 5'd8, 1, 0, 0, 0, 32'd2, 1);
    tick();
    set_in(1, 1, 1, 2'b10, 1, 0, 0, 2'b00, 5'd8, 32'h102, 32'h80FF7F01, 32'h0);
    expect_next("lb_a2", 32'h0000007F, 5'd8, 1, 0, 0, 0, 32'd3, 1);
    tick();
    set_in(1, 1, 1, 2'b10, 1, 0, 0, 2'b00, 5'd8, 32'h103, 32'h80FF7F01, 32'h0);
    expect_next("lb_a3", 32'h00000001, 5'd8, 1, 0, 0, 0, 32'd4, 1);
    tick();
    set_in(1, 1, 1, 2'b10, 0, 0, 0, 2'b00, 5'd8, 32'h100, 32'h80FF7F01, 32'h0);
    expect_next("lbu_a0", 32'h00000080, 5'd8, 1, 0, 0, 0, 32'd5, 1);
    tick();
    set_in(1, 1, 1, 2'b01, 1, 0, 0, 2'b00, 5'd8, 32'h102, 32'h1234ABCD, 32'h0);
    expect_next("lh_a2", 32'hFFFFABCD, 5'd8, 1, 0, 0, 0, 32'd6, 1);
    tick();

    // Link write overrides rw and FP target
    set_in(1, 0, 1, 2'b00, 0, 1, 0, 2'b01, 5'd7, 32'hDEAD, 32'h0, 32'h00400008);
    expect_next("jal", 32'h00400008, 5'd31, 1, 0, 0, 0, 32'd7, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd0, 32'h55, 32'h0, 32'h0);
    expect_next("alu_r0", 32'h55, 5'd0, 0, 0, 0, 0, 32'd8, 1);
    tick();

    // FP doubles: even pair writes, odd pair is misaligned
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b11, 5'd4, 32'h3FF, 32'h0, 32'h0);
    expect_next("fpd_r4", 32'h3FF, 5'd4, 0, 1, 1, 0, 32'd9, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b11, 5'd5, 32'h400, 32'h0, 32'h0);
    expect_next("fpd_r5", 32'h400, 5'd5, 0, 0, 0, 0, 32'd10, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd3, 32'h77, 32'h0, 32'h0);
    expect_next("after_fpd_r5", 32'h77, 5'd3, 1, 0, 0, 1, 32'd11, 1);
    tick();

    // Reset clears the sticky flag and counter
    ctl(1, 0, 0);
    expect_next("reset2", 32'h0, 5'd0, 0, 0, 0, 0, 32'd0, 1);
    tick();
    ctl(0, 0, 0);

    // Misaligned half load, then sticky flag across good instructions
    set_in(1, 1, 1, 2'b01, 1, 0, 0, 2'b00, 5'd9, 32'h201, 32'h1234ABCD, 32'h0);
    expect_next("lh_a1", 32'h00001234, 5'd9, 0, 0, 0, 0, 32'd0, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd3, 32'h77, 32'h0, 32'h0);
    expect_next("sticky1", 32'h77, 5'd3, 1, 0, 0, 1, 32'd1, 1);
    tick();
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd6, 32'h99, 32'h0, 32'h0);
    expect_next("sticky2", 32'h99, 5'd6, 1, 0, 0, 1, 32'd2, 1);
    tick();

    // Stall: outputs repeat, counter frozen, new input not captured
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd10, 32'hAAA, 32'h0, 32'h0);
    ctl(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      expect_next($sformatf("stall%0d", i), 32'h99, 5'd6, 1, 0, 0, 1, 32'd2, 1);
      tick();
    end
    ctl(0, 0, 0);
    expect_next("unstall", 32'hAAA, 5'd10, 1, 0, 0, 1, 32'd3, 1);
    tick();

    // Flush beats stall
    set_in(1, 0, 1, 2'b00, 0, 0, 0, 2'b00, 5'd11, 32'hBBB, 32'h0, 32'h0);
    ctl(0, 1, 1);
    expect_next("stall_flush", 32'h0, 5'd0, 0, 0, 0, 1, 32'd3, 1);
    tick();

    // Reset beats stall
    ctl(0, 0, 0);
    expect_next("refill", 32'hBBB, 5'd11, 1, 0, 0, 1, 32'd3, 1);
    tick();
    ctl(1, 1, 0);
    expect_next("reset_stall", 32'h0, 5'd0, 0, 0, 0, 0, 32'd0, 1);
    tick();
    ctl(0, 0, 0);
    set_in(0, 0, 0, 2'b00, 0, 0, 0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0);
    expect_next("idle_end", 32'h0, 5'd0, 0, 0, 0, 0, 32'd0, 1);
    tick();

    // Final report
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
